// File: rtl/rr_arbiter_if.sv
// -----------------------------------------------------------------------------
// rr_arbiter_if
//
// Purpose : Groups the request/grant bundle that sits between a set of
//           requesting lanes and the round-robin arbiter. The clock and reset
//           are kept out of the bundle and are passed as plain ports.
//
// Signals :
//   req_i      [REQ_NUM-1:0]  level-sensitive request vector, one bit per lane
//   gnt_o      [REQ_NUM-1:0]  one-hot grant, all zeros when nothing is granted
//   gnt_idx_o  [IDX_W-1:0]    binary index of the granted lane (0 when idle)
//   gnt_val_o                 high whenever gnt_o is non-zero
//
// Modports:
//   master : the requester side. It drives req_i and observes the grant.
//   slave  : the arbiter side. It observes req_i and drives the grant.
// -----------------------------------------------------------------------------
interface rr_arbiter_if #(
    parameter int REQ_NUM = 4
);
    localparam int IDX_W = $clog2(REQ_NUM);

    logic [REQ_NUM-1:0] req_i;
    logic [REQ_NUM-1:0] gnt_o;
    logic [IDX_W-1:0]   gnt_idx_o;
    logic               gnt_val_o;

    modport master (
        output req_i,
        input  gnt_o,
        input  gnt_idx_o,
        input  gnt_val_o
    );

    modport slave (
        input  req_i,
        output gnt_o,
        output gnt_idx_o,
        output gnt_val_o
    );
endinterface : rr_arbiter_if

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//
// Purpose : Round-robin arbiter with grant hold and forced timeout. It shares
//           one downstream resource among REQ_NUM requesters. The winner is
//           the first set request bit found when the search starts at a
//           rotating pointer. A grant is held while its owner keeps
//           requesting, for at most MAX_HOLD consecutive cycles. On release,
//           the next winner is granted on the same edge, so handoff has no
//           dead cycle. All outputs are registered, so there is no
//           combinational path from req_i to any output.
//
// Parameters:
//   REQ_NUM   number of requesters. It must be at least 2.
//   MAX_HOLD  maximum number of consecutive cycles one grant stays visible.
//             It must be at least 1.
//
// Ports   :
//   clk_i     rising-edge clock
//   srst_i    synchronous active-high reset
//   bus       rr_arbiter_if.slave, which carries req_i, gnt_o, gnt_idx_o
//             and gnt_val_o
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int REQ_NUM  = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic          clk_i,
    input  logic          srst_i,
    rr_arbiter_if.slave   bus
);
    localparam int IDX_W  = $clog2(REQ_NUM);
    localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    localparam logic [IDX_W-1:0]  LAST_IDX     = IDX_W'(REQ_NUM - 1);
    localparam logic [IDX_W:0]    REQ_NUM_EXT  = (IDX_W + 1)'(REQ_NUM);
    localparam logic [HOLD_W-1:0] HOLD_LAST    = HOLD_W'(MAX_HOLD - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t              state_q,   state_d;
    logic [IDX_W-1:0]    ptr_q,     ptr_d;
    logic [IDX_W-1:0]    owner_q,   owner_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [REQ_NUM-1:0]  gnt_q,     gnt_d;
    logic [IDX_W-1:0]    gnt_idx_q, gnt_idx_d;
    logic                gnt_val_q, gnt_val_d;

    // ------------------------------------------------------------------
    // Rotating-priority search
    // ------------------------------------------------------------------
    // The request vector is rotated right by ptr, so bit 0 of req_rot is
    // the highest-priority lane. The lowest set bit of req_rot gives the
    // offset from ptr. Adding the offset back to ptr, modulo REQ_NUM, gives
    // the absolute winner index.
    logic [2*REQ_NUM-1:0] req_dbl;
    logic [REQ_NUM-1:0]   req_rot;
    logic [IDX_W-1:0]     win_off;
    logic [IDX_W:0]       win_sum;
    logic [IDX_W-1:0]     win_idx;
    logic                 win_any;
    logic [REQ_NUM-1:0]   win_onehot;

    assign req_dbl = {bus.req_i, bus.req_i} >> ptr_q;
    assign req_rot = req_dbl[REQ_NUM-1:0];
    assign win_any = |bus.req_i;

    always_comb begin
        win_off = '0;
        // Scan downward so that the lowest set bit is the last one written.
        for (int i = REQ_NUM - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                win_off = IDX_W'(i);
            end
        end
    end

    always_comb begin
        win_sum = {1'b0, ptr_q} + {1'b0, win_off};
        if (win_sum >= REQ_NUM_EXT) begin
            win_sum = win_sum - REQ_NUM_EXT;
        end
        win_idx = win_sum[IDX_W-1:0];
    end

    // Decode the winner index to a one-hot grant vector.
    generate
        for (genvar gi = 0; gi < REQ_NUM; gi++) begin : g_onehot
            assign win_onehot[gi] = (win_idx == IDX_W'(gi));
        end
    endgenerate

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    logic owner_req;
    logic release_now;
    logic rearb;

    assign owner_req   = bus.req_i[owner_q];
    // Release when the owner drops its request, or when its grant has
    // already been visible for MAX_HOLD cycles. When MAX_HOLD is 1,
    // HOLD_LAST is 0, so every BUSY cycle re-arbitrates.
    assign release_now = (state_q == BUSY) && (!owner_req || (hold_cnt_q == HOLD_LAST));
    assign rearb       = (state_q == IDLE) || release_now;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        hold_cnt_d = hold_cnt_q;
        gnt_d      = gnt_q;
        gnt_idx_d  = gnt_idx_q;
        gnt_val_d  = gnt_val_q;

        if (rearb) begin
            if (win_any) begin
                state_d    = BUSY;
                gnt_d      = win_onehot;
                gnt_idx_d  = win_idx;
                gnt_val_d  = 1'b1;
                owner_d    = win_idx;
                // The new owner becomes the lowest priority for the next round.
                ptr_d      = (win_idx == LAST_IDX) ? '0 : win_idx + IDX_W'(1);
                hold_cnt_d = '0;
            end else begin
                // With no requests, go idle. ptr keeps its value, so fairness
                // continues from the same lane.
                state_d    = IDLE;
                gnt_d      = '0;
                gnt_idx_d  = '0;
                gnt_val_d  = 1'b0;
            end
        end else begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            owner_q    <= '0;
            hold_cnt_q <= '0;
            gnt_q      <= '0;
            gnt_idx_q  <= '0;
            gnt_val_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            hold_cnt_q <= hold_cnt_d;
            gnt_q      <= gnt_d;
            gnt_idx_q  <= gnt_idx_d;
            gnt_val_q  <= gnt_val_d;
        end
    end

    assign bus.gnt_o     = gnt_q;
    assign bus.gnt_idx_o = gnt_idx_q;
    assign bus.gnt_val_o = gnt_val_q;

endmodule : rr_arbiter

// File: tb/tb_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rr_arbiter
//
// Directed bench for rr_arbiter with REQ_NUM=4 and MAX_HOLD=4.
// The stimulus process drives one vector per cycle on the falling edge. It
// pushes the hand-computed grant expected after the next rising edge into a
// queue. The monitor process samples the outputs shortly after every rising
// edge, pops one expectation and compares gnt_o, gnt_idx_o and gnt_val_o.
// -----------------------------------------------------------------------------
module tb_rr_arbiter;
    localparam int REQ_NUM  = 4;
    localparam int MAX_HOLD = 4;
    localparam int IDX_W    = $clog2(REQ_NUM);

    typedef struct {
        logic [REQ_NUM-1:0] gnt;
        string              tag;
        int                 step;
    } exp_t;

    logic clk;
    logic srst;

    rr_arbiter_if #(.REQ_NUM(REQ_NUM)) bus ();

    rr_arbiter #(
        .REQ_NUM  (REQ_NUM),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk_i  (clk),
        .srst_i (srst),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   step_no  = 0;

    // One stimulus cycle: drive inputs on the falling edge and record the
    // outputs expected after the coming rising edge.
    task automatic drive(input logic [REQ_NUM-1:0] req, input logic rst,
                         input logic [REQ_NUM-1:0] exp_gnt, input string tag);
        exp_t e;
        @(negedge clk);
        bus.req_i = req;
        srst      = rst;
        e.gnt     = exp_gnt;
        e.tag     = tag;
        e.step    = step_no;
        exp_q.push_back(e);
        $display("step %0d %s: req=%b srst=%b expect gnt=%b", step_no, tag, req, rst, exp_gnt);
        step_no++;
    endtask

    task automatic drive_n(input int n, input logic [REQ_NUM-1:0] req, input logic rst,
                           input logic [REQ_NUM-1:0] exp_gnt, input string tag);
        for (int k = 0; k < n; k++) begin
            drive(req, rst, exp_gnt, tag);
        end
    endtask

    // Monitor and scoreboard
    initial begin : monitor
        exp_t               e;
        logic [IDX_W-1:0]   want_idx;
        logic               want_val;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e        = exp_q.pop_front();
                want_idx = '0;
                for (int b = 0; b < REQ_NUM; b++) begin
                    if (e.gnt[b]) want_idx = IDX_W'(b);
                end
                want_val = (e.gnt != '0);

                n_checks++;
                if (bus.gnt_o !== e.gnt) begin
                    n_fail++;
                    $display("FAIL step%0d_%s gnt_o: got %b want %b", e.step, e.tag, bus.gnt_o, e.gnt);
                end
                n_checks++;
                if (bus.gnt_idx_o !== want_idx) begin
                    n_fail++;
                    $display("FAIL step%0d_%s gnt_idx_o: got %0d want %0d", e.step, e.tag, bus.gnt_idx_o, want_idx);
                end
                n_checks++;
                if (bus.gnt_val_o !== want_val) begin
                    n_fail++;
                    $display("FAIL step%0d_%s gnt_val_o: got %b want %b", e.step, e.tag, bus.gnt_val_o, want_val);
                end
            end
        end
    end

    // Stimulus
    initial begin : stimulus
        srst      = 1'b1;
        bus.req_i = '0;

        // Reset with all lanes requesting: outputs stay 0, then lane 0 wins.
        drive_n(2, 4'b1111, 1'b1, 4'b0000, "reset");
        // Full load: every lane is held exactly MAX_HOLD cycles, with no gap.
        drive_n(4, 4'b1111, 1'b0, 4'b0001, "full_g0");
        drive_n(4, 4'b1111, 1'b0, 4'b0010, "full_g1");
        drive_n(4, 4'b1111, 1'b0, 4'b0100, "full_g2");
        drive_n(4, 4'b1111, 1'b0, 4'b1000, "full_g3");
        drive_n(4, 4'b1111, 1'b0, 4'b0001, "full_g0b");
        // All requests drop: the grant is released.
        drive  (4'b0000, 1'b0, 4'b0000, "drop_all");

        // Single requester: lane 1 is granted, then drops after 3 cycles.
        drive_n(3, 4'b0010, 1'b0, 4'b0010, "single");
        drive  (4'b0000, 1'b0, 4'b0000, "single_drop");

        // Early release with wrap-around: owner 1 is granted and the pointer
        // moves to 2. Bit 1 drops, bit 2 is clear, so lane 3 wins; then lane
        // 0 wins after wrapping.
        drive  (4'b0010, 1'b0, 4'b0010, "early_own1");
        drive  (4'b1011, 1'b0, 4'b0010, "early_hold");
        drive  (4'b1001, 1'b0, 4'b1000, "early_g3");
        drive  (4'b0001, 1'b0, 4'b0001, "early_wrap0");
        drive  (4'b0000, 1'b0, 4'b0000, "early_idle");

        // Sole requester timeout: the grant stays continuous through re-grants.
        drive_n(20, 4'b0100, 1'b0, 4'b0100, "sole_timeout");

        // Reset mid-grant: outputs clear, then lane 0 wins because ptr was
        // reset to 0.
        drive  (4'b1111, 1'b1, 4'b0000, "midrst");
        drive_n(4, 4'b1111, 1'b0, 4'b0001, "midrst_g0");
        drive_n(2, 4'b1111, 1'b0, 4'b0010, "midrst_g1");

        // Let the monitor drain the queue within a bounded number of cycles.
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) begin
            @(negedge clk);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_rr_arbiter

// File: doc/rr_arbiter.md
# rr_arbiter

Round-robin arbiter with grant hold and forced timeout. It shares one downstream resource among `REQ_NUM` requesters, such as a shared `priority_encoder` instance or its output bus. Winner selection is a rotating-priority search: the same "first set bit" search as the encoder, but started at a moving pointer. All outputs are registered. The block sits between the requesting lanes and the shared datapath's input mux select.

## Interface
- `REQ_NUM`, default 4: number of requesters. Must be ≥ 2.
- `MAX_HOLD`, default 8: maximum consecutive cycles one grant stays visible. Must be ≥ 1.
- `clk_i` in, 1: single clock. All logic is on the rising edge.
- `srst_i` in, 1: reset. Synchronous, active-high.
- `req_i` in, `REQ_NUM`: request vector, one bit per requester. It is level-sensitive and not latched.
- `gnt_o` out, `REQ_NUM`: one-hot grant, or all zeros when there is no grant.
- `gnt_idx_o` out, `$clog2(REQ_NUM)`: binary index of the granted requester. It is 0 when `gnt_val_o` is 0.
- `gnt_val_o` out, 1: high when `gnt_o` is non-zero.

## Operation
- Internal state:
  - `IDLE`/`BUSY` state flag.
  - `ptr`: width `$clog2(REQ_NUM)`; the highest-priority index for the next arbitration.
  - `owner`: the current grant index.
  - `hold_cnt`: width `$clog2(MAX_HOLD)`, minimum 1 bit.
- Arbitration function `arb(req, ptr)`:
  - Winner is the first set bit of `req`, searching `ptr`, `ptr+1`, …, `REQ_NUM-1`, then 0, …, `ptr-1`.
  - "None" if `req == 0`.
- Release condition in `BUSY` is either of:
  - `req_i[owner] == 0`.
  - `hold_cnt == MAX_HOLD-1`, meaning the grant has already been visible `MAX_HOLD` cycles.
- Arbitration happens on an edge when the state is `IDLE`, or when the state is `BUSY` and the release condition holds.
  - Winner w exists: `gnt_o <= 1<<w`, `gnt_idx_o <= w`, `gnt_val_o <= 1`, `owner <= w`, `ptr <= (w+1) mod REQ_NUM`, `hold_cnt <= 0`, state becomes `BUSY`.
  - No winner: `gnt_o <= 0`, `gnt_idx_o <= 0`, `gnt_val_o <= 0`, state becomes `IDLE`. `ptr` is unchanged.
- In `BUSY` without release: grant outputs hold and `hold_cnt` increments.
- Handoff is direct. A release with other requests pending grants the next winner on the same edge, with no dead cycle.
- Priority after a grant:
  - The previous owner becomes lowest priority because `ptr` is `owner+1`.
  - On timeout it may win again only if no other bit of `req_i` is set. In that case the grant stays continuous and `hold_cnt` restarts at 0.
- `MAX_HOLD == 1`: the block re-arbitrates every cycle while `BUSY`, which gives pure per-cycle round-robin.
- A request dropped before it is granted is simply not considered. Requesters must hold `req_i` until they see their `gnt_o` bit.
- `gnt_o`, `gnt_idx_o` and `gnt_val_o` are always mutually consistent. `gnt_o` is never multi-hot.

## Timing
- Reset (`srst_i` high at an edge): the next cycle has `gnt_o=0`, `gnt_idx_o=0`, `gnt_val_o=0`, state `IDLE`, `ptr=0`, `owner=0`, `hold_cnt=0`.
  - Reset overrides everything, including a grant in progress.
  - After reset, requester 0 has the highest priority.
- Grant latency: `req_i` sampled at edge t while `IDLE` gives grant outputs valid from the cycle after edge t. That is one cycle.
- Release latency: the owner's `req_i` sampled low at edge t removes or hands off the grant at edge t. It is visible the cycle after.
- Maximum continuous hold: exactly `MAX_HOLD` cycles of a given grant before forced re-arbitration.
- No combinational path from `req_i` to any output.

## Test plan
1. **Reset:** `REQ_NUM=4`, `MAX_HOLD=4`. Assert `srst_i` for 2 cycles with `req_i=4'b1111`.
   - Outputs stay 0 during reset.
   - The first cycle after release has `gnt_o=0`.
   - The next cycle has `gnt_o=4'b0001`, idx 0, val 1.
2. **Single requester:** `req_i=4'b0010` from edge t.
   - `gnt_o=4'b0010`, idx 1, val 1 from t+1.
   - Drop `req_i` at t+3: outputs return to 0 from the cycle after edge t+3.
3. **Full load fairness:** `req_i=4'b1111` held, `MAX_HOLD=4`.
   - Grants go 0, 1, 2, 3, 0, … with each index held exactly 4 cycles.
   - `gnt_val_o` never drops between grants.
4. **Early release with wrap-around:** owner 1 holds the grant, `req_i=4'b1011`; then the bit 1 request drops.
   - The next grant is index 3, since the search starts at 2 and bit 2 is clear.
   - The grant after that is index 0, with wrap-around.
5. **Sole requester timeout:** `req_i=4'b0100` held for 20 cycles, `MAX_HOLD=4`.
   - `gnt_o=4'b0100` continuously with no gap.
   - Internal `hold_cnt` wraps 0→3→0.
6. **Reset mid-grant:** owner 2 in `BUSY`, `srst_i` pulsed for 1 cycle, `req_i=4'b1111` held.
   - Outputs are 0 in the cycle after reset.
   - The next grant is index 0, which shows `ptr` reset to 0.
